// File: rtl/cell_fetch_arbiter.sv
// Arbitrates the single-port cell memory between the render pipeline and the
// simulation engine. Render reads always win so pixel timing stays fixed; sim
// accesses take whatever cycles render leaves idle. Fetched cells are unpacked
// into render flags with a fixed 2-cycle request-to-valid latency.
module cell_fetch_arbiter #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned SIGNAL_bits = 10,
    parameter int unsigned CELL_W      = SIGNAL_bits + 3,
    parameter int unsigned STARVE_MAX  = 64
) (
    input  logic                   Clk,
    input  logic                   Reset,
    // Render read port
    input  logic                   rnd_req,
    input  logic [ADDR_W-1:0]      rnd_addr,
    output logic                   rnd_valid,
    output logic                   renderAnt,
    output logic                   renderSugar,
    output logic                   renderNest,
    output logic [SIGNAL_bits-1:0] renderSignal,
    // Sim read/write port
    input  logic                   sim_req,
    input  logic                   sim_we,
    input  logic [ADDR_W-1:0]      sim_addr,
    input  logic [CELL_W-1:0]      sim_wdata,
    output logic                   sim_gnt,
    output logic                   sim_rvalid,
    output logic [CELL_W-1:0]      sim_rdata,
    output logic                   sim_starve,
    // Memory port
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_we,
    output logic [CELL_W-1:0]      mem_wdata,
    input  logic [CELL_W-1:0]      mem_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(STARVE_MAX);

    // Owner of the read whose data arrives on mem_rdata this cycle.
    typedef enum logic [1:0] {
        TagNone,
        TagRnd,
        TagSimRd
    } tag_e;

    tag_e tag_q, tag_d;

    logic [CNT_W-1:0] wait_q, wait_d;
    logic             starve_q;

    logic                   rnd_valid_q;
    logic                   ant_q;
    logic                   sugar_q;
    logic                   nest_q;
    logic [SIGNAL_bits-1:0] signal_q;

    logic              sim_rvalid_q;
    logic [CELL_W-1:0] sim_rdata_q;

    // Fixed-priority grant: render first, sim only in otherwise idle cycles.
    always_comb begin
        sim_gnt   = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (rnd_req) begin
            mem_addr = rnd_addr;
        end else if (sim_req) begin
            sim_gnt   = 1'b1;
            mem_addr  = sim_addr;
            mem_we    = sim_we;
            mem_wdata = sim_wdata;
        end
    end

    // Next tag and starvation counter; writes leave no read in flight.
    always_comb begin
        tag_d  = TagNone;
        wait_d = '0;
        if (rnd_req) begin
            tag_d = TagRnd;
        end else if (sim_gnt && !sim_we) begin
            tag_d = TagSimRd;
        end
        if (sim_req && !sim_gnt) begin
            wait_d = (wait_q == STARVE_CNT) ? wait_q : wait_q + 1'b1;
        end
    end

    // Tag, wait counter and registered starvation flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tag_q    <= TagNone;
            wait_q   <= '0;
            starve_q <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            wait_q   <= wait_d;
            starve_q <= (wait_d == STARVE_CNT);
        end
    end

    // Render capture: unpack the cell when the returning read is a render read.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rnd_valid_q <= 1'b0;
            ant_q       <= 1'b0;
            sugar_q     <= 1'b0;
            nest_q      <= 1'b0;
            signal_q    <= '0;
        end else begin
            rnd_valid_q <= (tag_q == TagRnd);
            if (tag_q == TagRnd) begin
                ant_q    <= mem_rdata[CELL_W-1];
                sugar_q  <= mem_rdata[CELL_W-2];
                nest_q   <= mem_rdata[CELL_W-3];
                signal_q <= mem_rdata[SIGNAL_bits-1:0];
            end
        end
    end

    // Sim capture: latch the raw cell when the returning read is a sim read.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sim_rvalid_q <= 1'b0;
            sim_rdata_q  <= '0;
        end else begin
            sim_rvalid_q <= (tag_q == TagSimRd);
            if (tag_q == TagSimRd) begin
                sim_rdata_q <= mem_rdata;
            end
        end
    end

    assign rnd_valid    = rnd_valid_q;
    assign renderAnt    = ant_q;
    assign renderSugar  = sugar_q;
    assign renderNest   = nest_q;
    assign renderSignal = signal_q;
    assign sim_rvalid   = sim_rvalid_q;
    assign sim_rdata    = sim_rdata_q;
    assign sim_starve   = starve_q;

endmodule

// File: tb/tb_cell_fetch_arbiter.sv
// Directed bench for cell_fetch_arbiter with a synchronous single-port RAM model.
module tb_cell_fetch_arbiter;

    localparam int ADDR_W      = 12;
    localparam int SIGNAL_bits = 10;
    localparam int CELL_W      = SIGNAL_bits + 3;
    localparam int STARVE_MAX  = 64;

    logic                   Clk = 1'b0;
    logic                   Reset;
    logic                   rnd_req;
    logic [ADDR_W-1:0]      rnd_addr;
    logic                   rnd_valid;
    logic                   renderAnt;
    logic                   renderSugar;
    logic                   renderNest;
    logic [SIGNAL_bits-1:0] renderSignal;
    logic                   sim_req;
    logic                   sim_we;
    logic [ADDR_W-1:0]      sim_addr;
    logic [CELL_W-1:0]      sim_wdata;
    logic                   sim_gnt;
    logic                   sim_rvalid;
    logic [CELL_W-1:0]      sim_rdata;
    logic                   sim_starve;
    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_we;
    logic [CELL_W-1:0]      mem_wdata;
    logic [CELL_W-1:0]      mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [CELL_W-1:0] mem     [0:4095];
    logic [CELL_W-1:0] exp_mem [0:4095];
    logic              mem_init_done = 1'b0;
    logic [CELL_W-1:0] last_cell;

    wire [CELL_W-1:0] rnd_cell = {renderAnt, renderSugar, renderNest, renderSignal};

    cell_fetch_arbiter #(
        .ADDR_W      (ADDR_W),
        .SIGNAL_bits (SIGNAL_bits),
        .CELL_W      (CELL_W),
        .STARVE_MAX  (STARVE_MAX)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .rnd_req      (rnd_req),
        .rnd_addr     (rnd_addr),
        .rnd_valid    (rnd_valid),
        .renderAnt    (renderAnt),
        .renderSugar  (renderSugar),
        .renderNest   (renderNest),
        .renderSignal (renderSignal),
        .sim_req      (sim_req),
        .sim_we       (sim_we),
        .sim_addr     (sim_addr),
        .sim_wdata    (sim_wdata),
        .sim_gnt      (sim_gnt),
        .sim_rvalid   (sim_rvalid),
        .sim_rdata    (sim_rdata),
        .sim_starve   (sim_starve),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 Clk = ~Clk;

    function automatic logic [CELL_W-1:0] init_cell(input int a);
        if (a == 16) return 13'h1123;  // ant=1, sugar=0, nest=0, signal=0x123
        return CELL_W'((a * 331 + 7) ^ (a << 5));
    endfunction

    function automatic int saddr(input int j);
        if (j == 1) return 32'h020;
        if (j == 3) return 32'h030;
        return 32'h060 + j;
    endfunction

    // Synchronous RAM: contents loaded on the first edge (inside reset).
    always @(posedge Clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_cell(i);
            mem_init_done <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset     = 1'b1;
        rnd_req   = 1'b0;
        rnd_addr  = '0;
        sim_req   = 1'b0;
        sim_we    = 1'b0;
        sim_addr  = '0;
        sim_wdata = '0;
        for (int i = 0; i < 4096; i++) exp_mem[i] = init_cell(i);

        // Reset state
        repeat (3) tick();
        check("rst_rnd_valid", 32'(rnd_valid), 0);
        check("rst_sim_rvalid", 32'(sim_rvalid), 0);
        check("rst_sim_starve", 32'(sim_starve), 0);
        check("rst_rnd_cell", 32'(rnd_cell), 0);
        check("rst_sim_rdata", 32'(sim_rdata), 0);
        Reset = 1'b0;
        tick();
        check("idle_mem_we", 32'(mem_we), 0);
        check("idle_mem_addr", 32'(mem_addr), 0);
        check("idle_rnd_valid", 32'(rnd_valid), 0);

        // Single render fetch of 0x010
        rnd_req  = 1'b1;
        rnd_addr = 12'h010;
        #1;
        check("t1_mem_addr", 32'(mem_addr), 32'h010);
        check("t1_mem_we", 32'(mem_we), 0);
        check("t1_valid_t0", 32'(rnd_valid), 0);
        tick();
        rnd_req = 1'b0;
        check("t1_valid_t1", 32'(rnd_valid), 0);
        tick();
        check("t1_valid_t2", 32'(rnd_valid), 1);
        check("t1_cell", 32'(rnd_cell), 32'h1123);
        check("t1_ant", 32'(renderAnt), 1);
        check("t1_signal", 32'(renderSignal), 32'h123);
        tick();
        check("t1_valid_t3", 32'(rnd_valid), 0);
        check("t1_hold", 32'(rnd_cell), 32'h1123);

        // 100 back-to-back render reads
        for (int i = 0; i < 102; i++) begin
            rnd_req  = (i < 100);
            rnd_addr = ADDR_W'(i);
            #1;
            check("t2_sim_gnt", 32'(sim_gnt), 0);
            if (i < 100) check("t2_mem_addr", 32'(mem_addr), i);
            if (i >= 2) begin
                check("t2_valid", 32'(rnd_valid), 1);
                check("t2_cell", 32'(rnd_cell), 32'(exp_mem[i-2]));
            end else begin
                check("t2_fill", 32'(rnd_valid), 0);
            end
            tick();
        end
        check("t2_after", 32'(rnd_valid), 0);

        // Sim write then read-back of 0x020
        rnd_req   = 1'b0;
        sim_req   = 1'b1;
        sim_we    = 1'b1;
        sim_addr  = 12'h020;
        sim_wdata = 13'h1FFF;
        exp_mem[12'h020] = 13'h1FFF;
        #1;
        check("t3_wr_gnt", 32'(sim_gnt), 1);
        check("t3_wr_we", 32'(mem_we), 1);
        check("t3_wr_addr", 32'(mem_addr), 32'h020);
        check("t3_wr_data", 32'(mem_wdata), 32'h1FFF);
        tick();
        sim_we    = 1'b0;
        sim_wdata = '0;
        #1;
        check("t3_rd_gnt", 32'(sim_gnt), 1);
        check("t3_rd_we", 32'(mem_we), 0);
        check("t3_rv0", 32'(sim_rvalid), 0);
        tick();
        sim_req = 1'b0;
        check("t3_no_wr_rvalid", 32'(sim_rvalid), 0);
        tick();
        check("t3_rvalid", 32'(sim_rvalid), 1);
        check("t3_rdata", 32'(sim_rdata), 32'h1FFF);
        tick();
        check("t3_rv_pulse", 32'(sim_rvalid), 0);
        check("t3_rdata_hold", 32'(sim_rdata), 32'h1FFF);

        // Starvation: sim write held against 70 render cycles
        sim_req   = 1'b1;
        sim_we    = 1'b1;
        sim_addr  = 12'h030;
        sim_wdata = 13'h0AAA;
        for (int c = 1; c <= 70; c++) begin
            rnd_req  = 1'b1;
            rnd_addr = ADDR_W'(c);
            #1;
            check("t4_gnt", 32'(sim_gnt), 0);
            check("t4_mem_we", 32'(mem_we), 0);
            check("t4_starve", 32'(sim_starve), (c >= STARVE_MAX + 1) ? 1 : 0);
            tick();
        end
        rnd_req = 1'b0;
        exp_mem[12'h030] = 13'h0AAA;
        #1;
        check("t4_late_gnt", 32'(sim_gnt), 1);
        check("t4_late_we", 32'(mem_we), 1);
        check("t4_late_addr", 32'(mem_addr), 32'h030);
        check("t4_starve_still", 32'(sim_starve), 1);
        tick();
        sim_req = 1'b0;
        sim_we  = 1'b0;
        check("t4_starve_clr", 32'(sim_starve), 0);
        repeat (3) tick();

        // Alternating render / sim reads; sim request held until granted
        last_cell = rnd_cell;
        for (int j = 0; j < 12; j++) begin
            rnd_req = 1'b0;
            sim_req = 1'b0;
            if (j < 10) begin
                sim_req  = 1'b1;
                sim_we   = 1'b0;
                sim_addr = ADDR_W'(saddr(j | 1));
                if ((j % 2) == 0) begin
                    rnd_req  = 1'b1;
                    rnd_addr = ADDR_W'(32'h040 + j);
                end
            end
            #1;
            if (j < 10) begin
                check("t5_gnt", 32'(sim_gnt), j % 2);
                check("t5_addr", 32'(mem_addr), ((j % 2) == 0) ? 32'h040 + j : saddr(j));
            end
            if (j >= 2 && (j - 2) < 10 && ((j - 2) % 2) == 0) begin
                check("t5_rvalid_on", 32'(rnd_valid), 1);
                check("t5_rcell", 32'(rnd_cell), 32'(exp_mem[32'h040 + j - 2]));
                last_cell = exp_mem[32'h040 + j - 2];
                check("t5_svalid_off", 32'(sim_rvalid), 0);
            end else if (j >= 2 && (j - 2) < 10) begin
                check("t5_svalid_on", 32'(sim_rvalid), 1);
                check("t5_sdata", 32'(sim_rdata), 32'(exp_mem[saddr(j - 2)]));
                check("t5_rvalid_off", 32'(rnd_valid), 0);
                check("t5_rcell_hold", 32'(rnd_cell), 32'(last_cell));
            end else begin
                check("t5_quiet_r", 32'(rnd_valid), 0);
                check("t5_quiet_s", 32'(sim_rvalid), 0);
            end
            tick();
        end

        // Reset one cycle after a render request
        rnd_req  = 1'b1;
        rnd_addr = 12'h010;
        tick();
        rnd_req = 1'b0;
        Reset   = 1'b1;
        #1;
        check("t6_rnd_valid", 32'(rnd_valid), 0);
        check("t6_rnd_cell", 32'(rnd_cell), 0);
        check("t6_sim_rvalid", 32'(sim_rvalid), 0);
        check("t6_sim_rdata", 32'(sim_rdata), 0);
        check("t6_starve", 32'(sim_starve), 0);
        tick();
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_no_pulse", 32'(rnd_valid), 0);
            check("t6_no_spulse", 32'(sim_rvalid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
